// File: rtl/request_arbiter.sv
// Round-robin arbiter in front of request_mux: one grant held until the
// downstream handshake, then the pointer advances past the served consumer.
module request_arbiter #(
    parameter  int NCONSUMERS = 8,
    localparam int SEL_W      = $clog2(NCONSUMERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCONSUMERS-1:0] req_valid,
    output logic [NCONSUMERS-1:0] req_ready,
    output logic [SEL_W-1:0]      select,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        select_q, select_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic [SEL_W-1:0]        ptr_next;
    logic [NCONSUMERS-1:0]   sel_onehot;
    logic [NCONSUMERS-1:0]   scan_vec;
    logic [SEL_W-1:0]        scan_base;
    logic [SEL_W:0]          scan_res;
    logic                    fire;

    // Returns {found, index} of the first set bit at or after base, wrapping.
    function automatic logic [SEL_W:0] pick_first(
        input logic [NCONSUMERS-1:0] v,
        input logic [SEL_W-1:0]      base
    );
        logic [SEL_W:0] r;
        int             idx;
        r = '0;
        for (int k = NCONSUMERS - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
            if (v[idx]) r = {1'b1, SEL_W'(idx)};
        end
        return r;
    endfunction

    assign out_valid  = (state_q == BUSY);
    assign select     = select_q;
    assign fire       = out_valid & out_ready;
    assign sel_onehot = {{(NCONSUMERS-1){1'b0}}, 1'b1} << select_q;
    assign req_ready  = fire ? sel_onehot : '0;
    assign ptr_next   = (select_q == SEL_W'(NCONSUMERS - 1)) ? '0
                                                             : select_q + 1'b1;

    // The just-served consumer is masked so others get a turn without a bubble.
    always_comb begin
        scan_vec  = req_valid;
        scan_base = ptr_q;
        if (state_q == BUSY) begin
            scan_vec  = req_valid & ~sel_onehot;
            scan_base = ptr_next;
        end
        scan_res = pick_first(scan_vec, scan_base);
    end

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (scan_res[SEL_W]) begin
                    state_d  = BUSY;
                    select_d = scan_res[SEL_W-1:0];
                end
            end
            BUSY: begin
                if (fire) begin
                    ptr_d = ptr_next;
                    if (scan_res[SEL_W]) begin
                        select_d = scan_res[SEL_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            select_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_request_arbiter.sv
// Scoreboard bench for request_arbiter: directed scenarios plus random
// traffic, checked against a queue-based round-robin reference model.
module tb_request_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [2:0]   select;
    logic         out_valid;
    logic         out_ready;

    int checks;
    int errors;

    int m_busy;
    int m_sel;
    int m_ptr;
    int m_served;

    int gq[$];
    int ovq[$];

    request_arbiter #(.NCONSUMERS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int base);
        for (int k = 0; k < N; k++) begin
            if (v[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    // One cycle: drive inputs after the edge and predict the next edge.
    task automatic step(input logic [N-1:0] rv, input logic o);
        int g;
        @(posedge clk);
        #1;
        req_valid = rv;
        out_ready = o;
        ovq.push_back(m_busy);
        m_served = -1;
        if (m_busy == 0) begin
            g = first_from(rv, m_ptr);
            if (g >= 0) begin
                m_busy = 1;
                m_sel  = g;
                gq.push_back(g);
            end
        end else if (o) begin
            m_served = m_sel;
            m_ptr    = (m_sel + 1) % N;
            g = first_from(rv & ~(8'h01 << m_sel), m_ptr);
            if (g >= 0) begin
                m_sel = g;
                gq.push_back(g);
            end else begin
                m_busy = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
        gq.delete();
        ovq.delete();
    endtask

    // Assert reset between edges, check the outputs drop at once, then release.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        check({tag, "_rst_out_valid"}, int'(out_valid), 0);
        check({tag, "_rst_select"}, int'(select), 0);
        check({tag, "_rst_req_ready"}, int'(req_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        int ev;
        int hs;
        int exp_rr;
        if (rst && ovq.size() > 0) begin
            ev = ovq.pop_front();
            check("out_valid", int'(out_valid), ev);
            hs = (ev != 0) && out_ready;
            exp_rr = 0;
            if (ev != 0) begin
                if (gq.size() == 0) begin
                    check("grant_queue_underflow", 1, 0);
                end else begin
                    check("select", int'(select), gq[0]);
                    if (hs) exp_rr = 1 << gq[0];
                end
            end
            check("req_ready", int'(req_ready), exp_rr);
            if (hs && gq.size() > 0) void'(gq.pop_front());
        end
    end

    initial begin
        logic [N-1:0] pending;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        m_served  = -1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_select", int'(select), 0);
        check("reset_req_ready", int'(req_ready), 0);
        rst = 1'b1;

        // single requester 2
        step(8'h04, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // all requesting: 0..7 then 0 with no bubble
        reset_mid("t2");
        repeat (10) step(8'hFF, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // back-pressure holds the grant
        reset_mid("t3");
        step(8'h28, 1'b0);
        repeat (4) step(8'h28, 1'b0);
        step(8'h28, 1'b1);
        step(8'h20, 1'b1);
        step(8'h00, 1'b1);

        // wrap after consumer 7
        reset_mid("t4");
        step(8'h80, 1'b1);
        step(8'h41, 1'b1);
        step(8'h40, 1'b1);
        step(8'h00, 1'b1);

        // reset while busy on 5, then 1 then 5
        reset_mid("t5a");
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        reset_mid("t5");
        step(8'h22, 1'b1);
        step(8'h22, 1'b1);
        step(8'h20, 1'b1);
        step(8'h00, 1'b1);

        // lone requester alternates
        reset_mid("t6");
        repeat (6) step(8'h10, 1'b1);
        step(8'h00, 1'b1);

        // random traffic obeying hold-until-ready
        pending = '0;
        for (int i = 0; i < 600; i++) begin
            if (m_served >= 0) pending[m_served] = 1'b0;
            pending |= N'($urandom & $urandom);
            step(pending, $urandom_range(0, 3) != 0);
        end
        repeat (N * 2 + 2) begin
            if (m_served >= 0) pending[m_served] = 1'b0;
            step(pending, 1'b1);
        end
        repeat (2) step(8'h00, 1'b1);
        @(posedge clk);
        #1;
        check("grants_drained", gq.size(), 0);
        check("idle_at_end", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
